// File: rtl/user_app_ctrl.sv
// Register-mapped run/abort/status controller for NUM_CH streaming memory agents.
// Holds per-channel address windows, a four-state run FSM, saturating cycle counters and sticky errors.
module user_app_ctrl #(
   parameter int NUM_CH        = 2,
   parameter int ADDRESS_WIDTH = 32,
   parameter int CNT_WIDTH     = 32
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [63:0]                       reg_in,
   input  logic [255:0]                      reg_wr,
   output logic [2047:0]                     reg_out,
   input  logic [NUM_CH-1:0]                 req_in,
   output logic [NUM_CH-1:0]                 run,
   output logic [NUM_CH-1:0]                 abort,
   output logic [NUM_CH*ADDRESS_WIDTH-1:0]   ral,
   output logic [NUM_CH*ADDRESS_WIDTH-1:0]   rah,
   output logic [NUM_CH*ADDRESS_WIDTH-1:0]   wal,
   output logic [NUM_CH*ADDRESS_WIDTH-1:0]   wah,
   output logic                              irq
);

   localparam int AW     = ADDRESS_WIDTH;
   localparam int STAT_W = 64 + 32 * NUM_CH;

   typedef enum logic [1:0] {IDLE, ARMED, BUSY, DONE} state_t;

   state_t               state     [NUM_CH];
   state_t               state_nxt [NUM_CH];
   logic [CNT_WIDTH-1:0] cnt       [NUM_CH];
   logic [CNT_WIDTH-1:0] cnt_nxt   [NUM_CH];
   logic [NUM_CH-1:0]    err, err_nxt;
   logic [NUM_CH-1:0]    run_lvl, abort_lvl, run_prev, abort_prev;
   logic [NUM_CH-1:0]    run_req, abort_req, run_nxt, abort_nxt;
   logic                 busy_any, done_all;
   logic [STAT_W-1:0]    status, status_q;
   logic                 unused_bits;

   // A request held high over several writes only counts on its first cycle.
   assign run_lvl   = {NUM_CH{reg_wr[0]}} & reg_in[2 +: NUM_CH];
   assign abort_lvl = {NUM_CH{reg_wr[4]}} & reg_in[32 +: NUM_CH];
   assign run_req   = run_lvl & ~run_prev;
   assign abort_req = abort_lvl & ~abort_prev;

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         // NOTE: every output of this block gets a default first, so no path can infer a latch.
         state_nxt[c] = state[c];
         cnt_nxt[c]   = cnt[c];
         err_nxt[c]   = err[c];
         run_nxt[c]   = 1'b0;
         abort_nxt[c] = 1'b0;
         if (abort_req[c]) begin
            state_nxt[c] = IDLE;
            abort_nxt[c] = 1'b1;
         end else begin
            if ((state[c] == ARMED || state[c] == BUSY) && cnt[c] != '1)
               cnt_nxt[c] = cnt[c] + 1'b1;
            unique case (state[c])
               IDLE, DONE: if (run_req[c]) begin
                  state_nxt[c] = ARMED;
                  run_nxt[c]   = 1'b1;
                  cnt_nxt[c]   = '0;
                  err_nxt[c]   = 1'b0;
               end
               ARMED: begin
                  if (run_req[c]) err_nxt[c] = 1'b1;
                  if (req_in[c]) state_nxt[c] = BUSY;
               end
               BUSY: begin
                  if (run_req[c]) err_nxt[c] = 1'b1;
                  if (!req_in[c]) state_nxt[c] = DONE;
               end
            endcase
         end
      end
   end

   always_comb begin
      busy_any = 1'b0;
      done_all = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (state[c] == ARMED || state[c] == BUSY) busy_any = 1'b1;
         if (state[c] == DONE) done_all = 1'b1;
      end
      done_all = done_all & ~busy_any;
   end

   always_comb begin
      status    = '0;
      status[0] = done_all;
      status[1] = busy_any;
      for (int c = 0; c < NUM_CH; c++) begin
         status[2 + c]                  = req_in[c];
         status[16 + c]                 = (state[c] == DONE);
         status[32 + c]                 = err[c];
         status[64 + 32*c +: CNT_WIDTH] = cnt[c];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: the per-channel arrays are few flops, not RAM, so they reset like any register.
         for (int c = 0; c < NUM_CH; c++) begin
            state[c] <= IDLE;
            cnt[c]   <= '0;
         end
         err        <= '0;
         run_prev   <= '0;
         abort_prev <= '0;
         run        <= '0;
         abort      <= '0;
         ral        <= '0;
         rah        <= '0;
         wal        <= '0;
         wah        <= '0;
         status_q   <= '0;
         irq        <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
         for (int c = 0; c < NUM_CH; c++) begin
            state[c] <= state_nxt[c];
            cnt[c]   <= cnt_nxt[c];
            if (reg_wr[8 + 16*c])  ral[c*AW +: AW] <= reg_in[AW-1:0];
            if (reg_wr[12 + 16*c]) rah[c*AW +: AW] <= reg_in[32 +: AW];
            if (reg_wr[16 + 16*c]) wal[c*AW +: AW] <= reg_in[AW-1:0];
            if (reg_wr[20 + 16*c]) wah[c*AW +: AW] <= reg_in[32 +: AW];
         end
         err        <= err_nxt;
         run_prev   <= run_lvl;
         abort_prev <= abort_lvl;
         run        <= run_nxt;
         abort      <= abort_nxt;
         status_q   <= status;
         // status_q[0] is done_all one cycle late, so this fires on its registered rising edge.
         irq        <= done_all & ~status_q[0];
      end
   end

   assign reg_out     = {{(2048 - STAT_W){1'b0}}, status_q};
   assign unused_bits = ^{reg_wr, reg_in};

endmodule
